// File: rtl/mips_mmio_defines.sv
// Shared constants for the MIPS memory-port bridge: MMIO region select,
// register offsets within the region and TX_STATUS bit positions.
package mips_mmio_defines;

    localparam logic [15:0] MMIO_BASE_HI_DEF = 16'hFFFF;

    typedef enum logic [1:0] {
        OFF_LED  = 2'd0,
        OFF_TX   = 2'd1,
        OFF_STAT = 2'd2,
        OFF_CYC  = 2'd3
    } mmio_off_e;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 4;

endpackage

// File: rtl/mips_tx_fifo.sv
// Synchronous FIFO for the transmit byte stream; a push while full is
// accepted only when the head is popped in the same cycle.
module mips_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    output logic [W-1:0]  data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o,
    output logic          rejected_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop, accept;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CW'(DEPTH));
    assign count_o    = count_q;
    assign pop        = pop_i & ~empty_o;
    assign accept     = push_i & (~full_o | pop);
    assign rejected_o = push_i & ~accept;
    assign data_o     = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);
        if (accept && !pop)      count_d = count_q + CW'(1);
        else if (pop && !accept) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries data only; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/mips_mmio_bridge.sv
// Routes multicycle-MIPS memory accesses to RAM or to the MMIO block (LED,
// TX FIFO, cycle counter) with matching one-cycle read latency.
module mips_mmio_bridge
    import mips_mmio_defines::*;
#(
    parameter int          N            = 32,
    parameter logic [15:0] MMIO_BASE_HI = MMIO_BASE_HI_DEF,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          LED_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     core_addr,
    input  logic [N-1:0]     core_wdata,
    input  logic             core_we,
    output logic [N-1:0]     core_rdata,
    output logic [N-1:0]     ram_addr,
    output logic [N-1:0]     ram_wdata,
    output logic             ram_we,
    input  logic [N-1:0]     ram_rdata,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [LED_W-1:0] leds
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic             is_mmio;
    mmio_off_e        off;
    logic             wr_mmio, wr_led, wr_tx, wr_stat, wr_cyc;
    logic             fifo_full, fifo_empty, fifo_rej, pop;
    logic [CW-1:0]    fifo_count;
    logic [N-1:0]     stat_word, rd_sel;

    logic [LED_W-1:0] led_q, led_d;
    logic             ovf_q, ovf_d;
    logic [31:0]      cyc_q, cyc_d;
    logic             sel_mmio_q;
    logic [N-1:0]     mmio_rdata_q;

    assign is_mmio   = (core_addr[31:16] == MMIO_BASE_HI);
    assign off       = mmio_off_e'(core_addr[3:2]);
    assign wr_mmio   = core_we & is_mmio;
    assign wr_led    = wr_mmio & (off == OFF_LED);
    assign wr_tx     = wr_mmio & (off == OFF_TX);
    assign wr_stat   = wr_mmio & (off == OFF_STAT);
    assign wr_cyc    = wr_mmio & (off == OFF_CYC);

    assign ram_addr  = core_addr;
    assign ram_wdata = core_wdata;
    assign ram_we    = core_we & ~is_mmio;

    assign tx_valid  = ~fifo_empty;
    assign pop       = tx_valid & tx_ready;
    assign leds      = led_q;

    mips_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst),
        .push_i     (wr_tx),
        .data_i     (core_wdata[7:0]),
        .pop_i      (pop),
        .data_o     (tx_data),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count),
        .rejected_o (fifo_rej)
    );

    always_comb begin
        stat_word                          = '0;
        stat_word[STAT_FULL]               = fifo_full;
        stat_word[STAT_EMPTY]              = fifo_empty;
        stat_word[STAT_OVF]                = ovf_q;
        stat_word[STAT_CNT_LSB +: 4]       = 4'(fifo_count);
    end

    // Read value reflects register state before this edge's updates.
    always_comb begin
        rd_sel = '0;
        case (off)
            OFF_LED:  rd_sel = N'(led_q);
            OFF_TX:   rd_sel = '0;
            OFF_STAT: rd_sel = stat_word;
            OFF_CYC:  rd_sel = N'(cyc_q);
            default:  rd_sel = '0;
        endcase
    end

    always_comb begin
        led_d = wr_led ? core_wdata[LED_W-1:0] : led_q;
        ovf_d = ovf_q;
        if (wr_stat)  ovf_d = 1'b0;
        if (fifo_rej) ovf_d = 1'b1;
        cyc_d = wr_cyc ? 32'd0 : cyc_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q        <= '0;
            ovf_q        <= 1'b0;
            cyc_q        <= '0;
            sel_mmio_q   <= 1'b0;
            mmio_rdata_q <= '0;
        end else begin
            led_q        <= led_d;
            ovf_q        <= ovf_d;
            cyc_q        <= cyc_d;
            sel_mmio_q   <= is_mmio;
            mmio_rdata_q <= rd_sel;
        end
    end

    assign core_rdata = sel_mmio_q ? mmio_rdata_q : ram_rdata;

endmodule

// File: tb/tb_mips_mmio_bridge.sv
// Self-checking bench for mips_mmio_bridge: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_mips_mmio_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        core_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_we;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [15:0] leds;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    byte unsigned m_q[$];
    logic [15:0]  m_led;
    bit           m_ovf;
    logic [31:0]  m_cyc;
    bit           m_sel;
    logic [31:0]  m_rd;

    localparam logic [31:0] A_LED  = 32'hFFFF_0000;
    localparam logic [31:0] A_TX   = 32'hFFFF_0004;
    localparam logic [31:0] A_STAT = 32'hFFFF_0008;
    localparam logic [31:0] A_CYC  = 32'hFFFF_000C;

    mips_mmio_bridge dut (
        .clk        (clk),
        .rst        (rst),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_we    (core_we),
        .core_rdata (core_rdata),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .leds       (leds)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        int sz = m_q.size();
        return 32'((sz % 16) * 16) + (m_ovf ? 32'd4 : 32'd0)
             + ((sz == 0) ? 32'd2 : 32'd0) + ((sz == 8) ? 32'd1 : 32'd0);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_led = '0;
        m_ovf = 0;
        m_cyc = '0;
        m_sel = 0;
        m_rd  = '0;
    endtask

    task automatic model_edge(input logic [31:0] a, input logic [31:0] w, input logic we, input logic rdy);
        bit mmio, wr, pop, pushed;
        int off;
        mmio   = (a[31:16] == 16'hFFFF);
        off    = int'(a[3:2]);
        wr     = we && mmio;
        pop    = (m_q.size() != 0) && rdy;
        pushed = 0;
        m_sel  = mmio;
        case (off)
            0: m_rd = {16'h0, m_led};
            1: m_rd = 32'h0;
            2: m_rd = m_status();
            default: m_rd = m_cyc;
        endcase
        m_cyc = (wr && off == 3) ? 32'h0 : m_cyc + 32'h1;
        if (wr && off == 0) m_led = w[15:0];
        if (wr && off == 2) m_ovf = 0;
        if (wr && off == 1) begin
            if (m_q.size() < 8 || pop) pushed = 1;
            else m_ovf = 1;
        end
        if (pop) void'(m_q.pop_front());
        if (pushed) m_q.push_back(w[7:0]);
    endtask

    task automatic check_outputs();
        bit mmio;
        mmio = (core_addr[31:16] == 16'hFFFF);
        chk("ram_addr", ram_addr, core_addr);
        chk("ram_wdata", ram_wdata, core_wdata);
        chk("ram_we", {31'h0, ram_we}, {31'h0, core_we & ~mmio});
        chk("tx_valid", {31'h0, tx_valid}, (m_q.size() != 0) ? 32'h1 : 32'h0);
        chk("tx_data", {24'h0, tx_data}, (m_q.size() != 0) ? {24'h0, m_q[0]} : 32'h0);
        chk("leds", {16'h0, leds}, {16'h0, m_led});
        chk("core_rdata", core_rdata, m_sel ? m_rd : ram_rdata);
    endtask

    // Called at posedge+1; applies one access for one clock.
    task automatic step(input logic [31:0] a, input logic [31:0] w, input logic we, input logic rdy);
        core_addr  = a;
        core_wdata = w;
        core_we    = we;
        tx_ready   = rdy;
        ram_rdata  = $urandom;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge(a, w, we, rdy);
        #1;
    endtask

    task automatic pulse_reset();
        core_addr = 32'h0; core_wdata = 32'h0; core_we = 1'b0; tx_ready = 1'b0;
        ram_rdata = $urandom;
        #2 rst = 1'b0;
        #1;
        chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
        chk("rst_leds", {16'h0, leds}, 32'h0);
        model_reset();
        @(negedge clk);
        chk("rst_core_rdata", core_rdata, ram_rdata);
        rst = 1'b1;
        @(posedge clk);
        model_edge(32'h0, 32'h0, 1'b0, 1'b0);
        #1;
    endtask

    initial begin
        logic [31:0] v1, v2, a;
        rst = 1'b0;
        core_addr = '0; core_wdata = '0; core_we = 1'b0; tx_ready = 1'b0; ram_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        pulse_reset();

        // Routing
        step(32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 1'b0);
        chk("store_ram_we", {31'h0, ram_we}, 32'h1);
        step(A_LED, 32'h0000_1234, 1'b1, 1'b0);
        chk("store_led_ram_we", {31'h0, ram_we}, 32'h0);
        chk("led_after_store", {16'h0, leds}, 32'h1234);
        step(A_LED, 32'h0, 1'b0, 1'b0);
        chk("led_read", core_rdata, 32'h0000_1234);

        // Overflow: nine pushes into an eight-entry FIFO
        for (int i = 0; i < 9; i++) step(A_TX, 32'h41 + 32'(i), 1'b1, 1'b0);
        step(A_STAT, 32'h0, 1'b0, 1'b0);
        chk("stat_overflow", core_rdata, 32'h0000_0085);
        for (int i = 0; i < 8; i++) begin
            chk("drain_byte", {24'h0, tx_data}, 32'h41 + 32'(i));
            step(32'h0, 32'h0, 1'b0, 1'b1);
        end
        chk("drained_valid", {31'h0, tx_valid}, 32'h0);
        step(A_STAT, 32'h0, 1'b1, 1'b0);
        step(A_STAT, 32'h0, 1'b0, 1'b0);
        chk("stat_cleared", core_rdata, 32'h0000_0002);

        // Full FIFO with push and pop in the same cycle
        for (int i = 0; i < 8; i++) step(A_TX, 32'h10 + 32'(i), 1'b1, 1'b0);
        step(A_TX, 32'h5A, 1'b1, 1'b1);
        step(A_STAT, 32'h0, 1'b0, 1'b0);
        chk("stat_full_no_ovf", core_rdata, 32'h0000_0081);
        for (int i = 0; i < 7; i++) step(32'h0, 32'h0, 1'b0, 1'b1);
        chk("last_byte", {24'h0, tx_data}, 32'h5A);
        step(32'h0, 32'h0, 1'b0, 1'b1);
        chk("empty_after_5a", {31'h0, tx_valid}, 32'h0);

        // Cycle counter
        step(A_CYC, 32'h0, 1'b0, 1'b0);
        v1 = core_rdata;
        for (int i = 0; i < 4; i++) step(32'h0, 32'h0, 1'b0, 1'b0);
        step(A_CYC, 32'h0, 1'b0, 1'b0);
        v2 = core_rdata;
        chk("cyc_delta", v2 - v1, 32'd5);
        step(A_CYC, 32'h0, 1'b1, 1'b0);
        step(A_CYC, 32'h0, 1'b0, 1'b0);
        chk("cyc_cleared", core_rdata, 32'h0);
        force dut.cyc_q = 32'hFFFF_FFFF;
        #1 release dut.cyc_q;
        m_cyc = 32'hFFFF_FFFF;
        step(A_CYC, 32'h0, 1'b0, 1'b0);
        chk("cyc_max", core_rdata, 32'hFFFF_FFFF);
        step(A_CYC, 32'h0, 1'b0, 1'b0);
        chk("cyc_wrap", core_rdata, 32'h0);

        // Async reset with entries queued
        for (int i = 0; i < 3; i++) step(A_TX, 32'h70 + 32'(i), 1'b1, 1'b0);
        pulse_reset();
        step(A_STAT, 32'h0, 1'b0, 1'b0);
        chk("stat_post_reset", core_rdata, 32'h0000_0002);
        chk("leds_post_reset", {16'h0, leds}, 32'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) != 0) a = {16'hFFFF, 16'($urandom)};
            else a = {16'($urandom_range(0, 16'hFFFE)), 16'($urandom)};
            step(a, $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
